// File: rtl/pipeline_hazard_controller.sv
// Execute-stage hazard controller: load-use stalls, taken-branch flushes,
// and ownership of the multi-cycle MULT/DIV unit with HI/LO reader stalls.
// Also keeps a saturating count of PC-stall cycles for performance work.
//
// Signalling: every output is meaningful every cycle (no valid/ready pair).
// Stall/flush outputs are combinational from the current Decode/Execute
// contents; startMulDiv is a one-cycle pulse that the MULT/DIV unit must
// accept unconditionally; mulDivBusy/mulDivDone come from registered state.
module pipeline_hazard_controller #(
   parameter int MULDIV_LATENCY    = 32,
   parameter int STALL_COUNT_WIDTH = 32
) (
   input  logic                         clock,
   input  logic                         resetMachine,
   input  logic [4:0]                   rsAddress_Decode,
   input  logic [4:0]                   rtAddress_Decode,
   input  logic                         usesRt_Decode,
   input  logic                         startMulDiv_Decode,
   input  logic                         readHiLo_Decode,
   input  logic                         enableReadDataMemory_Execute,
   input  logic                         enableWriteRegisterFile_Execute,
   input  logic [4:0]                   addressWriteRegisterFile_Execute,
   input  logic                         enableBranchProgramCounter_Execute,
   output logic                         stallProgramCounter,
   output logic                         stallFetchDecode,
   output logic                         flushFetchDecode,
   output logic                         flushDecodeExecute,
   output logic                         startMulDiv,
   output logic                         mulDivBusy,
   output logic                         mulDivDone,
   output logic [STALL_COUNT_WIDTH-1:0] stallCycles
);

   // Latency is at most 255, so the remaining-cycle counter fits in 8 bits.
   localparam logic [7:0] LAST_COUNT = 8'(MULDIV_LATENCY - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t                         r_state;
   logic [7:0]                     r_count;
   logic [STALL_COUNT_WIDTH-1:0]   r_stallCycles;

   logic w_active;
   logic w_branch;
   logic w_loadUse;
   logic w_busy;
   logic w_done;
   logic w_mulDivHazard;
   logic w_stall;
   logic w_issue;

   // Hazard terms; everything is forced low while reset is held.
   assign w_active       = ~resetMachine;
   assign w_branch       = w_active & enableBranchProgramCounter_Execute;
   assign w_loadUse      = w_active
                           & enableReadDataMemory_Execute
                           & enableWriteRegisterFile_Execute
                           & (addressWriteRegisterFile_Execute != 5'd0)
                           & ((addressWriteRegisterFile_Execute == rsAddress_Decode)
                              | (usesRt_Decode
                                 & (addressWriteRegisterFile_Execute == rtAddress_Decode)));
   assign w_busy         = (r_state == ST_BUSY);
   assign w_done         = w_busy & (r_count == 8'd0);
   assign w_mulDivHazard = w_active & w_busy & (readHiLo_Decode | startMulDiv_Decode);

   // A taken branch overrides any stall: the Decode instruction is wrong-path.
   assign w_stall = ~w_branch & (w_loadUse | w_mulDivHazard);

   // A MULT/DIV issues only from IDLE, and never when it is wrong-path or
   // still waiting for its load operand.
   assign w_issue = w_active & ~w_busy & startMulDiv_Decode & ~w_branch & ~w_loadUse;

   assign stallProgramCounter = w_stall;
   assign stallFetchDecode    = w_stall;
   assign flushFetchDecode    = w_branch;
   assign flushDecodeExecute  = w_branch | w_stall;
   assign startMulDiv         = w_issue;
   assign mulDivBusy          = w_busy;
   assign mulDivDone          = w_done;
   assign stallCycles         = r_stallCycles;

   // MULT/DIV occupancy FSM: BUSY lasts exactly MULDIV_LATENCY cycles and a
   // taken branch does not abort it; only reset does.
   always_ff @(posedge clock or posedge resetMachine) begin
      if (resetMachine) begin
         r_state <= ST_IDLE;
         r_count <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state <= ST_BUSY;
                  r_count <= LAST_COUNT;
               end
            end
            ST_BUSY: begin
               if (r_count == 8'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= 8'd0;
            end
         endcase
      end
   end

   // Performance counter of PC-stall cycles, saturating at all-ones.
   always_ff @(posedge clock or posedge resetMachine) begin
      if (resetMachine) begin
         r_stallCycles <= '0;
      end else if (w_stall && (r_stallCycles != {STALL_COUNT_WIDTH{1'b1}})) begin
         r_stallCycles <= r_stallCycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances share one input stream,
// a short-latency / 4-bit-counter one and a latency-8 / 32-bit-counter one.
// The driver pushes the expected outputs of both into a queue every cycle;
// a negedge monitor pops and compares against the live DUT outputs.
module tb_pipeline_hazard_controller;

  localparam int LA = 4;
  localparam int WA = 4;
  localparam int LB = 8;
  localparam int WB = 32;

  logic       clock;
  logic       resetMachine;
  logic [4:0] rsAddress_Decode;
  logic [4:0] rtAddress_Decode;
  logic       usesRt_Decode;
  logic       startMulDiv_Decode;
  logic       readHiLo_Decode;
  logic       enableReadDataMemory_Execute;
  logic       enableWriteRegisterFile_Execute;
  logic [4:0] addressWriteRegisterFile_Execute;
  logic       enableBranchProgramCounter_Execute;

  logic          stall_pc_a, stall_fd_a, flush_fd_a, flush_de_a, start_a, busy_a, done_a;
  logic [WA-1:0] cycles_a;
  logic          stall_pc_b, stall_fd_b, flush_fd_b, flush_de_b, start_b, busy_b, done_b;
  logic [WB-1:0] cycles_b;

  pipeline_hazard_controller #(.MULDIV_LATENCY(LA), .STALL_COUNT_WIDTH(WA)) dut_a (
    .clock                              (clock),
    .resetMachine                       (resetMachine),
    .rsAddress_Decode                   (rsAddress_Decode),
    .rtAddress_Decode                   (rtAddress_Decode),
    .usesRt_Decode                      (usesRt_Decode),
    .startMulDiv_Decode                 (startMulDiv_Decode),
    .readHiLo_Decode                    (readHiLo_Decode),
    .enableReadDataMemory_Execute       (enableReadDataMemory_Execute),
    .enableWriteRegisterFile_Execute    (enableWriteRegisterFile_Execute),
    .addressWriteRegisterFile_Execute   (addressWriteRegisterFile_Execute),
    .enableBranchProgramCounter_Execute (enableBranchProgramCounter_Execute),
    .stallProgramCounter                (stall_pc_a),
    .stallFetchDecode                   (stall_fd_a),
    .flushFetchDecode                   (flush_fd_a),
    .flushDecodeExecute                 (flush_de_a),
    .startMulDiv                        (start_a),
    .mulDivBusy                         (busy_a),
    .mulDivDone                         (done_a),
    .stallCycles                        (cycles_a)
  );

  pipeline_hazard_controller #(.MULDIV_LATENCY(LB), .STALL_COUNT_WIDTH(WB)) dut_b (
    .clock                              (clock),
    .resetMachine                       (resetMachine),
    .rsAddress_Decode                   (rsAddress_Decode),
    .rtAddress_Decode                   (rtAddress_Decode),
    .usesRt_Decode                      (usesRt_Decode),
    .startMulDiv_Decode                 (startMulDiv_Decode),
    .readHiLo_Decode                    (readHiLo_Decode),
    .enableReadDataMemory_Execute       (enableReadDataMemory_Execute),
    .enableWriteRegisterFile_Execute    (enableWriteRegisterFile_Execute),
    .addressWriteRegisterFile_Execute   (addressWriteRegisterFile_Execute),
    .enableBranchProgramCounter_Execute (enableBranchProgramCounter_Execute),
    .stallProgramCounter                (stall_pc_b),
    .stallFetchDecode                   (stall_fd_b),
    .flushFetchDecode                   (flush_fd_b),
    .flushDecodeExecute                 (flush_de_b),
    .startMulDiv                        (start_b),
    .mulDivBusy                         (busy_b),
    .mulDivDone                         (done_b),
    .stallCycles                        (cycles_b)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Per instance: cycles of MULT/DIV occupancy still ahead (0 = free) and the
  // stall count as a plain integer clipped at the counter's maximum.
  int     lat  [2] = '{LA, LB};
  longint cmax [2] = '{64'd15, 64'hFFFF_FFFF};
  int     rem  [2];
  longint cnt  [2];

  // Expected word per instance: 7 flags then the counter widened to 32 bits.
  logic [77:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [38:0] model_cycle(input int i, input logic rst,
      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
      input logic smd, input logic rhl, input logic ld, input logic wr,
      input logic [4:0] wa, input logic br);
    logic lu, busy, hz, stall, start, done;
    logic [38:0] e;
    if (rst) begin
      rem[i] = 0;
      cnt[i] = 0;
      return 39'd0;
    end
    lu    = ld && wr && (wa != 5'd0) && ((wa == rs) || (urt && (wa == rt)));
    busy  = (rem[i] > 0);
    done  = (rem[i] == 1);
    hz    = busy && (rhl || smd);
    stall = !br && (lu || hz);
    start = !busy && smd && !br && !lu;
    e = {stall, stall, br, br | stall, start, busy, done, 32'(cnt[i])};
    if (busy) rem[i] = rem[i] - 1;
    if (start) rem[i] = lat[i];
    if (stall && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
      input logic urt, input logic smd, input logic rhl, input logic ld,
      input logic wr, input logic [4:0] wa, input logic br);
    logic [38:0] ea, eb;
    @(posedge clock);
    #1;
    resetMachine                       = rst;
    rsAddress_Decode                   = rs;
    rtAddress_Decode                   = rt;
    usesRt_Decode                      = urt;
    startMulDiv_Decode                 = smd;
    readHiLo_Decode                    = rhl;
    enableReadDataMemory_Execute       = ld;
    enableWriteRegisterFile_Execute    = wr;
    addressWriteRegisterFile_Execute   = wa;
    enableBranchProgramCounter_Execute = br;
    ea = model_cycle(0, rst, rs, rt, urt, smd, rhl, ld, wr, wa, br);
    eb = model_cycle(1, rst, rs, rt, urt, smd, rhl, ld, wr, wa, br);
    exp_q.push_back({ea, eb});
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) drive(0, 5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) drive(1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  // Load into r8 in Execute, add reading rs=8 in Decode.
  task automatic load_use_rs;
    drive(0, 5'd8, 5'd3, 1, 0, 0, 1, 1, 5'd8, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [77:0] e;
    logic [38:0] act_a, act_b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      act_a = {stall_pc_a, stall_fd_a, flush_fd_a, flush_de_a, start_a, busy_a, done_a,
               32'(cycles_a)};
      act_b = {stall_pc_b, stall_fd_b, flush_fd_b, flush_de_b, start_b, busy_b, done_b,
               32'(cycles_b)};
      total++;
      if (act_a !== e[77:39]) begin
        bad++;
        $display("FAIL inst_a cycle %0d: flags(pc,fd,ffd,fde,st,busy,done)=%b cnt=%0d, want flags=%b cnt=%0d",
                 cyc, act_a[38:32], act_a[31:0], e[77:71], e[70:39]);
      end
      total++;
      if (act_b !== e[38:0]) begin
        bad++;
        $display("FAIL inst_b cycle %0d: flags(pc,fd,ffd,fde,st,busy,done)=%b cnt=%0d, want flags=%b cnt=%0d",
                 cyc, act_b[38:32], act_b[31:0], e[38:32], e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetMachine                       = 1'b1;
    rsAddress_Decode                   = '0;
    rtAddress_Decode                   = '0;
    usesRt_Decode                      = 1'b0;
    startMulDiv_Decode                 = 1'b0;
    readHiLo_Decode                    = 1'b0;
    enableReadDataMemory_Execute       = 1'b0;
    enableWriteRegisterFile_Execute    = 1'b0;
    addressWriteRegisterFile_Execute   = '0;
    enableBranchProgramCounter_Execute = 1'b0;
    rem = '{0, 0};
    cnt = '{0, 0};

    do_reset(2);
    nop(2);

    // load-use on rs, then the same shape with the load writing r0
    load_use_rs();
    nop(1);
    drive(0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0);
    nop(1);

    // load-use on rt for a store, then rt match with usesRt=0 (addi)
    drive(0, 5'd2, 5'd9, 1, 0, 0, 1, 1, 5'd9, 0);
    nop(1);
    drive(0, 5'd2, 5'd9, 0, 0, 0, 1, 1, 5'd9, 0);
    nop(1);

    // MULT at T, MFHI held in Decode from T+2 until it proceeds
    drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    nop(1);
    for (int k = 0; k < 4; k++) drive(0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0);
    nop(10);

    // back-to-back MULT: the second is held until the first IDLE cycle
    drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    for (int k = 0; k < 10; k++) drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    nop(10);

    // taken branch with a load-use and a MULT in Decode
    drive(0, 5'd8, 5'd0, 0, 1, 0, 1, 1, 5'd8, 1);
    nop(2);

    // branch during BUSY does not abort the operation
    drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    drive(0, 5'd1, 5'd2, 0, 0, 0, 0, 0, 5'd0, 1);
    nop(9);

    // reset in busy cycle 2 of the latency-8 instance, then a fresh MULT
    drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    nop(1);
    do_reset(1);
    nop(1);
    drive(0, 5'd4, 5'd5, 1, 1, 0, 0, 0, 5'd0, 0);
    nop(10);

    // counter saturation on the 4-bit instance: 14, then 15 and hold
    do_reset(1);
    for (int k = 0; k < 14; k++) load_use_rs();
    nop(1);
    for (int k = 0; k < 4; k++) load_use_rs();
    nop(2);

    // randomized traffic with small register numbers to force matches
    for (int k = 0; k < 600; k++) begin
      logic rst;
      rst = ($urandom_range(0, 99) == 0);
      drive(rst,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
    end
    nop(2);

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
